// File: rtl/div_seq_core_if.sv
// ---------------------------------------------------------------------------
// div_seq_core_if
// Handshake and operand/result bundle for the sequential signed divider.
//   start        requester -> core   operation request (sampled when idle)
//   dividend     requester -> core   signed dividend
//   divisor      requester -> core   signed divisor
//   busy         core -> requester   operation in progress
//   done         core -> requester   one-cycle completion pulse
//   quotient     core -> requester   signed quotient
//   remainder    core -> requester   signed remainder
//   div_by_zero  core -> requester   last divisor was zero
//   overflow     core -> requester   last operation was MIN / -1
// master: requester side, slave: divider core side.
// ---------------------------------------------------------------------------
interface div_seq_core_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_seq_core.sv
// ---------------------------------------------------------------------------
// div_seq_core
// Sequential signed divider: restoring shift/subtract on operand magnitudes,
// one quotient bit per cycle, followed by sign correction (C semantics:
// quotient truncates toward zero, remainder takes the dividend's sign).
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   div_seq_core_if.slave (start/busy/done handshake, operands, results)
// Optional feature macro: DIV_REM_OUT_EN
//   defined     remainder is computed, sign-corrected and driven
//   undefined   remainder output is tied to zero
// ---------------------------------------------------------------------------
module div_seq_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    div_seq_core_if.slave        bus
);

    localparam int unsigned MAG_W = WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Magnitude of a two's-complement value; MIN maps to 2^(WIDTH-1) as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        mag = v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    logic [2:0]       state,      state_nxt;
    logic [WIDTH-1:0] dvd_q,      dvd_nxt;
    logic [WIDTH-1:0] dsr_q,      dsr_nxt;
    logic [WIDTH-1:0] dsr_mag_q,  dsr_mag_nxt;
    // Partial remainder after restore is always below |divisor| <= 2^(WIDTH-1),
    // so WIDTH bits hold it; the shifted value uses the full MAG_W bits.
    logic [WIDTH-1:0] r_q,        r_nxt;
    logic [WIDTH-1:0] q_q,        q_nxt;
    logic [CNT_W-1:0] cnt_q,      cnt_nxt;
    logic             q_sign_q,   q_sign_nxt;
    logic             busy_q,     busy_nxt;
    logic             done_q,     done_nxt;
    logic             dz_q,       dz_nxt;
    logic             ov_q,       ov_nxt;
    logic [WIDTH-1:0] quo_q,      quo_nxt;
`ifdef DIV_REM_OUT_EN
    logic             r_sign_q,   r_sign_nxt;
    logic [WIDTH-1:0] rem_q,      rem_nxt;
`endif

    logic [MAG_W-1:0] r_shift;
    logic [MAG_W-1:0] dsr_ext;
    logic             r_ge;

    // Shift/compare datapath for one restoring iteration.
    assign r_shift = {r_q, q_q[WIDTH-1]};
    assign dsr_ext = {1'b0, dsr_mag_q};
    assign r_ge    = (r_shift >= dsr_ext);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            dvd_q     <= '0;
            dsr_q     <= '0;
            dsr_mag_q <= '0;
            r_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            q_sign_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
            quo_q     <= '0;
`ifdef DIV_REM_OUT_EN
            r_sign_q  <= 1'b0;
            rem_q     <= '0;
`endif
        end else begin
            state     <= state_nxt;
            dvd_q     <= dvd_nxt;
            dsr_q     <= dsr_nxt;
            dsr_mag_q <= dsr_mag_nxt;
            r_q       <= r_nxt;
            q_q       <= q_nxt;
            cnt_q     <= cnt_nxt;
            q_sign_q  <= q_sign_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            dz_q      <= dz_nxt;
            ov_q      <= ov_nxt;
            quo_q     <= quo_nxt;
`ifdef DIV_REM_OUT_EN
            r_sign_q  <= r_sign_nxt;
            rem_q     <= rem_nxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        dvd_nxt     = dvd_q;
        dsr_nxt     = dsr_q;
        dsr_mag_nxt = dsr_mag_q;
        r_nxt       = r_q;
        q_nxt       = q_q;
        cnt_nxt     = cnt_q;
        q_sign_nxt  = q_sign_q;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        dz_nxt      = dz_q;
        ov_nxt      = ov_q;
        quo_nxt     = quo_q;
`ifdef DIV_REM_OUT_EN
        r_sign_nxt  = r_sign_q;
        rem_nxt     = rem_q;
`endif

        case (state)
            // DONE accepts a start too: that edge is the one that clears done.
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    dvd_nxt   = bus.dividend;
                    dsr_nxt   = bus.divisor;
                    busy_nxt  = 1'b1;
                    state_nxt = S_LOAD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end

            // The dividend sign fill would be discarded here anyway, so the
            // magnitude loop starts from a cleared partial remainder.
            S_LOAD: begin
                q_nxt       = mag(dvd_q);
                dsr_mag_nxt = mag(dsr_q);
                r_nxt       = '0;
                cnt_nxt     = '0;
                q_sign_nxt  = dvd_q[WIDTH-1] ^ dsr_q[WIDTH-1];
`ifdef DIV_REM_OUT_EN
                r_sign_nxt  = dvd_q[WIDTH-1];
`endif
                state_nxt   = (dsr_q == '0) ? S_FIX : S_ITER;
            end

            S_ITER: begin
                if (r_ge) begin
                    r_nxt = WIDTH'(r_shift - dsr_ext);
                    q_nxt = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_nxt = r_shift[WIDTH-1:0];
                    q_nxt = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_nxt = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_nxt = S_FIX;
                end
            end

            // Sign correction; MIN / -1 wraps naturally to MIN.
            S_FIX: begin
                if (dsr_q == '0) begin
                    quo_nxt = ALL_ONES;
                    dz_nxt  = 1'b1;
                    ov_nxt  = 1'b0;
`ifdef DIV_REM_OUT_EN
                    rem_nxt = dvd_q;
`endif
                end else begin
                    quo_nxt = q_sign_q ? (~q_q + 1'b1) : q_q;
                    dz_nxt  = 1'b0;
                    ov_nxt  = (dvd_q == MIN_NEG) && (dsr_q == ALL_ONES);
`ifdef DIV_REM_OUT_EN
                    rem_nxt = r_sign_q ? (~r_q + 1'b1) : r_q;
`endif
                end
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = S_DONE;
            end

            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.div_by_zero = dz_q;
    assign bus.overflow    = ov_q;
`ifdef DIV_REM_OUT_EN
    assign bus.remainder   = rem_q;
`else
    assign bus.remainder   = '0;
`endif

endmodule

// File: tb/tb_div_seq_core.sv
// ---------------------------------------------------------------------------
// tb_div_seq_core
// Scoreboard bench for div_seq_core: directed operations push hand-computed
// results; a monitor pops and compares on every done pulse, including the
// start-to-done latency.
// ---------------------------------------------------------------------------
module tb_div_seq_core;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         dz;
        logic         ov;
        int           lat;
        int           start_edge;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];

    div_seq_core_if #(.WIDTH(W)) bus ();

    div_seq_core #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rexp(input logic [W-1:0] r);
`ifdef DIV_REM_OUT_EN
        rexp = r;
`else
        rexp = (r == r) ? '0 : '0;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient",    32'(bus.quotient),    32'(e.quo));
                chk("remainder",   32'(bus.remainder),   32'(e.rem));
                chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
                chk("overflow",    32'(bus.overflow),    32'(e.ov));
                chk("latency",     32'(cyc - e.start_edge), 32'(e.lat));
                chk("busy_with_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    // Called at a negedge: drives start for the next rising edge, ends one negedge later.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic dz, input logic ov);
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        e.quo = q; e.rem = rexp(r); e.dz = dz; e.ov = ov;
        e.lat = (b == '0) ? 2 : 18;
        e.start_edge = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 16'hDEAD;
        bus.divisor  = 16'h0BAD;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        cyc = 0; n_chk = 0; n_fail = 0;
        rst = 1'b0;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",     32'(bus.busy),        32'd0);
        chk("rst_done",     32'(bus.done),        32'd0);
        chk("rst_quotient", 32'(bus.quotient),    32'd0);
        chk("rst_rem",      32'(bus.remainder),   32'd0);
        chk("rst_dz",       32'(bus.div_by_zero), 32'd0);
        chk("rst_ov",       32'(bus.overflow),    32'd0);
        rst = 1'b1;
        @(negedge clk);

        issue(16'd100,  16'd7,      16'h000E, 16'h0002, 1'b0, 1'b0); wait_drain();
        issue(16'hFF9C, 16'd7,      16'hFFF2, 16'hFFFE, 1'b0, 1'b0); wait_drain();
        issue(16'd100,  16'hFFF9,   16'hFFF2, 16'h0002, 1'b0, 1'b0); wait_drain();
        issue(16'h8000, 16'hFFFF,   16'h8000, 16'h0000, 1'b0, 1'b1); wait_drain();
        issue(16'h8000, 16'h0001,   16'h8000, 16'h0000, 1'b0, 1'b0); wait_drain();
        issue(16'd1234, 16'h0000,   16'hFFFF, 16'h04D2, 1'b1, 1'b0); wait_drain();
        issue(16'hFFF9, 16'h0000,   16'hFFFF, 16'hFFF9, 1'b1, 1'b0); wait_drain();
        issue(16'd7,    16'd100,    16'h0000, 16'h0007, 1'b0, 1'b0); wait_drain();
        issue(16'h7FFF, 16'h8000,   16'h0000, 16'h7FFF, 1'b0, 1'b0); wait_drain();
        issue(16'h8000, 16'h8000,   16'h0001, 16'h0000, 1'b0, 1'b0); wait_drain();
        issue(16'hFFFF, 16'h0001,   16'hFFFF, 16'h0000, 1'b0, 1'b0); wait_drain();

        // Start pulsed mid-operation with other operands must be ignored.
        issue(16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;

        // Back-to-back: next start sampled on the edge that clears done.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        chk("b2b_done_seen", 32'(bus.done), 32'd1);
        issue(16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0);
        wait_drain();

        // Asynchronous reset mid-operation aborts and clears outputs at once.
        issue(16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy",     32'(bus.busy),        32'd0);
        chk("abort_done",     32'(bus.done),        32'd0);
        chk("abort_quotient", 32'(bus.quotient),    32'd0);
        chk("abort_rem",      32'(bus.remainder),   32'd0);
        chk("abort_dz",       32'(bus.div_by_zero), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        chk("abort_no_done", 32'(bus.busy), 32'd0);

        issue(16'd50, 16'd5, 16'h000A, 16'h0000, 1'b0, 1'b0); wait_drain();

        repeat (25) @(negedge clk);
        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
